// File: rtl/line_dma_pkg.sv
// Shared types and constants for the line DMA writer: FSM states, status word
// layout and the byte-to-128-bit-word address shift.
package line_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARM       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_BURST     = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    localparam int STAT_BUSY_BIT    = 31;
    localparam int STAT_OVF_BIT     = 30;
    localparam int STAT_CFG_ERR_BIT = 29;
    localparam int STAT_WRAP_LSB    = 24;
    localparam int STAT_OFFSET_LSB  = 0;

    localparam int WORD_SHIFT = 4;

    function automatic logic [31:0] pack_status(
        input logic        busy,
        input logic        ovf,
        input logic        cfg_err,
        input logic [4:0]  wrap,
        input logic [23:0] offset
    );
        logic [31:0] s;
        s = '0;
        s[STAT_BUSY_BIT]           = busy;
        s[STAT_OVF_BIT]            = ovf;
        s[STAT_CFG_ERR_BIT]        = cfg_err;
        s[STAT_WRAP_LSB +: 5]      = wrap;
        s[STAT_OFFSET_LSB +: 24]   = offset;
        return s;
    endfunction

endpackage

// File: rtl/line_dma_fifo.sv
// Synchronous first-word-fall-through FIFO. i_clr empties it in one cycle while
// still capturing a word pushed in that same cycle.
module line_dma_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic             w_pop;
    logic             w_push;
    logic             w_mem_we;
    logic [AW-1:0]    w_wr_addr;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_pop     = i_pop && !o_empty;
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_mem_we  = i_clr ? i_push : w_push;
    assign w_wr_addr = i_clr ? '0 : r_wr_ptr;

    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clr) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= AW'(i_push);
            r_count  <= (AW+1)'(i_push);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/line_dma_writer.sv
// Streams 128-bit line words into a ring buffer in SDRAM via fixed-length Avalon bursts.
// Optional macro LINE_DMA_WRITER_OVF_CNT_EN adds the saturating dropped-word counter.
module line_dma_writer
    import line_dma_pkg::*;
#(
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enable,
    input  logic [31:0]  i_dma_adr,
    input  logic [31:0]  i_dma_buf_size,
    input  logic [127:0] i_data,
    input  logic         i_valid,
    output logic [27:0]  o_sdram0_address,
    output logic [7:0]   o_sdram0_burstcount,
    output logic         o_sdram0_write,
    output logic [127:0] o_sdram0_writedata,
    output logic [15:0]  o_sdram0_byteenable,
    input  logic         i_sdram0_waitrequest,
    output logic [31:0]  o_dma_status,
    output logic [15:0]  o_ovf_cnt
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [23:0] BURST_W = 24'(BURST_LEN);

    state_t       r_state;
    state_t       w_next;
    logic         r_en_d;
    logic [27:0]  r_base;
    logic [23:0]  r_size;
    logic [23:0]  r_offset;
    logic [4:0]   r_wrap;
    logic         r_cfg_err;
    logic         r_ovf;
    logic [7:0]   r_beat;
    logic [31:0]  r_status;

    logic         w_en_rise;
    logic [23:0]  w_size_raw;
    logic [23:0]  w_size_words;
    logic [23:0]  w_off_next;
    logic         w_write;
    logic         w_beat_ok;
    logic         w_last_beat;
    logic         w_fifo_clr;
    logic         w_in_push;
    logic         w_drop;
    logic         w_burst_out;
    logic [127:0] w_fifo_data;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic [CW-1:0] w_fifo_count;
    logic         w_unused;

    assign w_unused = ^{i_dma_adr[WORD_SHIFT-1:0], i_dma_buf_size[31:28],
                        i_dma_buf_size[WORD_SHIFT-1:0]};

    assign w_en_rise    = i_enable && !r_en_d;
    assign w_size_raw   = i_dma_buf_size[WORD_SHIFT +: 24];
    assign w_size_words = w_size_raw - (w_size_raw % BURST_W);
    assign w_off_next   = r_offset + BURST_W;

    assign w_write     = (r_state == S_BURST) && !w_fifo_empty;
    assign w_beat_ok   = w_write && !i_sdram0_waitrequest;
    assign w_last_beat = w_beat_ok && (r_beat == 8'(BURST_LEN - 1));

    // ARM flushes stale data; DRAIN throws away the tail of an aborted line.
    assign w_fifo_clr = (r_state == S_ARM) || (r_state == S_DRAIN);
    assign w_in_push  = i_valid && (r_state != S_IDLE);
    assign w_drop     = w_in_push && w_fifo_full && !w_beat_ok && !w_fifo_clr;

    line_dma_fifo #(
        .WIDTH (128),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_fifo_clr),
        .i_push  (w_in_push),
        .i_data  (i_data),
        .i_pop   (w_beat_ok),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_en_rise) w_next = S_ARM;
            S_ARM:       w_next = (w_size_words < BURST_W) ? S_IDLE : S_WAIT_DATA;
            S_WAIT_DATA: begin
                if (!i_enable) begin
                    w_next = S_DRAIN;
                end else if (w_fifo_count >= CW'(BURST_LEN)) begin
                    w_next = S_BURST;
                end
            end
            S_BURST:     if (w_last_beat) w_next = i_enable ? S_WAIT_DATA : S_DRAIN;
            S_DRAIN:     w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_base    <= '0;
            r_size    <= '0;
            r_offset  <= '0;
            r_wrap    <= '0;
            r_cfg_err <= 1'b0;
            r_ovf     <= 1'b0;
            r_beat    <= '0;
            r_status  <= '0;
        end else begin
            r_state <= w_next;
            r_en_d  <= i_enable;
            if (r_state == S_ARM) begin
                r_base    <= i_dma_adr[31:WORD_SHIFT];
                r_size    <= w_size_words;
                r_offset  <= '0;
                r_wrap    <= '0;
                r_cfg_err <= (w_size_words < BURST_W);
                r_ovf     <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end
                // Ring size is a whole number of bursts, so equality is the only wrap case.
                if (w_last_beat) begin
                    if (w_off_next == r_size) begin
                        r_offset <= '0;
                        r_wrap   <= r_wrap + 1'b1;
                    end else begin
                        r_offset <= w_off_next;
                    end
                end
            end
            if (r_state != S_BURST || w_last_beat) begin
                r_beat <= '0;
            end else if (w_beat_ok) begin
                r_beat <= r_beat + 1'b1;
            end
            r_status <= pack_status(r_state != S_IDLE, r_ovf, r_cfg_err, r_wrap, r_offset);
        end
    end

`ifdef LINE_DMA_WRITER_OVF_CNT_EN
    logic [15:0] r_ovf_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf_cnt <= '0;
        end else if (r_state == S_ARM) begin
            r_ovf_cnt <= '0;
        end else if (w_drop && r_ovf_cnt != 16'hFFFF) begin
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
    end

    assign o_ovf_cnt = i_rst ? 16'h0 : r_ovf_cnt;
`else
    assign o_ovf_cnt = 16'h0;
`endif

    // Bus outputs are forced quiet during reset so an abort takes effect at once.
    assign w_burst_out         = (r_state == S_BURST) && !i_rst;
    assign o_sdram0_write      = w_write && !i_rst;
    assign o_sdram0_address    = w_burst_out ? (r_base + {4'h0, r_offset}) : '0;
    assign o_sdram0_burstcount = w_burst_out ? 8'(BURST_LEN) : '0;
    assign o_sdram0_byteenable = w_burst_out ? 16'hFFFF : 16'h0000;
    assign o_sdram0_writedata  = w_burst_out ? w_fifo_data : '0;
    assign o_dma_status        = i_rst ? '0 : r_status;

endmodule

// File: tb/tb_line_dma_writer.sv
// Directed bench for line_dma_writer: ring bursts, stalls, config error, overflow,
// enable drop and mid-burst reset, with a per-beat expected queue.
module tb_line_dma_writer;
    localparam int BL = 8;
    localparam int FD = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [31:0]  adr;
    logic [31:0]  bsize;
    logic [127:0] din;
    logic         din_vld;
    logic [27:0]  o_addr;
    logic [7:0]   o_bcnt;
    logic         o_wr;
    logic [127:0] o_wdata;
    logic [15:0]  o_be;
    logic         wreq;
    logic [31:0]  o_status;
    logic [15:0]  o_ovf;

    int n_pass = 0;
    int n_checks = 0;
    int beats = 0;
    int write_cycles = 0;
    int b0;
    int w0;
    logic [127:0] exp_q[$];
    logic [27:0]  exp_addr_q[$];

    always #5 clk = ~clk;

    line_dma_writer #(
        .BURST_LEN  (BL),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_enable             (en),
        .i_dma_adr            (adr),
        .i_dma_buf_size       (bsize),
        .i_data               (din),
        .i_valid              (din_vld),
        .o_sdram0_address     (o_addr),
        .o_sdram0_burstcount  (o_bcnt),
        .o_sdram0_write       (o_wr),
        .o_sdram0_writedata   (o_wdata),
        .o_sdram0_byteenable  (o_be),
        .i_sdram0_waitrequest (wreq),
        .o_dma_status         (o_status),
        .o_ovf_cnt            (o_ovf)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [127:0] mk(input int t, input int k);
        return {32'(t), 32'(k), ~32'(k), 32'hC0FF_EE00 + 32'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_burst(input int t, input int k0, input logic [27:0] a);
        for (int i = 0; i < BL; i++) begin
            exp_q.push_back(mk(t, k0 + i));
            exp_addr_q.push_back(a);
        end
    endtask

    task automatic stream(input int t, input int k0, input int n);
        for (int i = 0; i < n; i++) begin
            din_vld = 1'b1;
            din = mk(t, k0 + i);
            tick();
        end
        din_vld = 1'b0;
        din = '0;
    endtask

    task automatic wait_write(input string tag, input int lim);
        for (int i = 0; i < lim && !o_wr; i++) tick();
        check(tag, o_wr, 1'b1);
    endtask

    task automatic wait_drain(input string tag, input int lim);
        for (int i = 0; i < lim && exp_q.size() != 0; i++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    // Every cycle write is asserted the bus must present the expected head beat.
    always @(negedge clk) begin
        if (!rst && o_wr) begin
            write_cycles++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", o_wr, 1'b0);
            end else begin
                check("beat_addr", o_addr, exp_addr_q[0]);
                check("beat_bcnt", o_bcnt, 8'(BL));
                check("beat_be", o_be, 16'hFFFF);
                check("beat_data", o_wdata, exp_q[0]);
                if (!wreq) begin
                    void'(exp_q.pop_front());
                    void'(exp_addr_q.pop_front());
                    beats++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; adr = '0; bsize = '0;
        din = '0; din_vld = 1'b0; wreq = 1'b0;
        repeat (3) tick();
        check("rst_write", o_wr, 1'b0);
        check("rst_addr", o_addr, 28'h0);
        check("rst_bcnt", o_bcnt, 8'h0);
        check("rst_wdata", o_wdata, 128'h0);
        check("rst_status", o_status, 32'h0);
        check("rst_ovf_cnt", o_ovf, 16'h0);
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_status", o_status, 32'h0);

        // Two bursts fill a 16-word ring and wrap it once.
        adr = 32'h2000_0000; bsize = 32'h100; en = 1'b1;
        repeat (2) tick();
        exp_burst(1, 0, 28'h200_0000);
        exp_burst(1, 8, 28'h200_0008);
        b0 = beats;
        stream(1, 0, 16);
        wait_drain("t030_done", 200);
        repeat (3) tick();
        check("t030_beats", beats - b0, 16);
        check("t030_status", o_status, 32'h8100_0000);

        // Waitrequest stall on the fourth beat.
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        repeat (2) tick();
        exp_burst(2, 0, 28'h200_0000);
        b0 = beats; w0 = write_cycles;
        stream(2, 0, 8);
        wait_write("t031_write_rise", 20);
        repeat (3) tick();
        wreq = 1'b1;
        repeat (3) tick();
        wreq = 1'b0;
        wait_drain("t031_done", 100);
        tick();
        check("t031_beats", beats - b0, 8);
        check("t031_write_cycles", write_cycles - w0, 11);
        check("t031_status", o_status, 32'h8000_0008);

        // Ring smaller than one burst is a configuration error.
        en = 1'b0;
        repeat (3) tick();
        bsize = 32'h40; en = 1'b1;
        w0 = write_cycles;
        repeat (2) tick();
        stream(3, 0, 4);
        repeat (3) tick();
        check("t032_status", o_status, 32'h2000_0000);
        check("t032_no_write", write_cycles - w0, 0);
        check("t032_ovf_cnt", o_ovf, 16'h0);

        // Bus stalled while 40 words arrive: the FIFO keeps 32, drops 8.
        en = 1'b0; wreq = 1'b1; bsize = 32'h100;
        tick();
        en = 1'b1;
        repeat (2) tick();
        exp_burst(4, 0, 28'h200_0000);
        exp_burst(4, 8, 28'h200_0008);
        exp_burst(4, 16, 28'h200_0000);
        exp_burst(4, 24, 28'h200_0008);
        stream(4, 0, 40);
        repeat (2) tick();
        check("t033_status_stalled", o_status, 32'hC000_0000);
`ifdef LINE_DMA_WRITER_OVF_CNT_EN
        check("t033_ovf_cnt", o_ovf, 16'd8);
`else
        check("t033_ovf_cnt", o_ovf, 16'd0);
`endif
        wreq = 1'b0;
        wait_drain("t033_done", 400);
        repeat (3) tick();
        check("t033_status_done", o_status, 32'hC200_0000);

        // Enable dropped mid-burst: the burst still completes, then the FSM idles.
        exp_burst(5, 0, 28'h200_0000);
        b0 = beats; w0 = write_cycles;
        stream(5, 0, 10);
        wait_write("t034_write_rise", 20);
        repeat (2) tick();
        en = 1'b0;
        wait_drain("t034_done", 100);
        repeat (4) tick();
        check("t034_beats", beats - b0, 8);
        check("t034_write_cycles", write_cycles - w0, 8);
        check("t034_status", o_status, 32'h4200_0008);

        // Reset in the middle of a burst aborts it; restart begins at offset 0.
        en = 1'b1;
        repeat (2) tick();
        exp_burst(6, 0, 28'h200_0000);
        stream(6, 0, 8);
        wait_write("t035_write_rise", 20);
        repeat (5) tick();
        rst = 1'b1; en = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        #1;
        check("t035_rst_write", o_wr, 1'b0);
        check("t035_rst_addr", o_addr, 28'h0);
        check("t035_rst_wdata", o_wdata, 128'h0);
        check("t035_rst_status", o_status, 32'h0);
        check("t035_rst_ovf_cnt", o_ovf, 16'h0);
        tick();
        check("t035_write_next", o_wr, 1'b0);
        rst = 1'b0;
        repeat (2) tick();
        check("t035_status_idle", o_status, 32'h0);
        check("t035_write_idle", o_wr, 1'b0);
        en = 1'b1;
        repeat (2) tick();
        exp_burst(7, 0, 28'h200_0000);
        b0 = beats;
        stream(7, 0, 8);
        wait_drain("t035_done", 100);
        repeat (3) tick();
        check("t035_beats", beats - b0, 8);
        check("t035_status", o_status, 32'h8000_0008);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
